// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator. The decoder feeds one output register
// backed by a skid register, and an illegal-instruction counter saturates at all-ones.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt,
    input  logic             clr_cnt
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;

    logic [6:0]       opcode_s;
    logic [2:0]       funct3_s;
    logic             is_shift_s;
    logic [11:0]      imm_s_s;
    logic [12:0]      imm_b_s;
    logic [31:0]      imm_u_s;
    logic [20:0]      imm_j_s;
    logic [XLEN-1:0]  dec_imm_s;
    logic [2:0]       dec_fmt_s;
    logic             dec_ill_s;

    logic             out_valid_r, out_valid_nxt_s;
    logic [XLEN-1:0]  out_imm_r, out_imm_nxt_s;
    logic [2:0]       out_fmt_r, out_fmt_nxt_s;
    logic             out_ill_r, out_ill_nxt_s;
    logic             skid_valid_r, skid_valid_nxt_s;
    logic [XLEN-1:0]  skid_imm_r, skid_imm_nxt_s;
    logic [2:0]       skid_fmt_r, skid_fmt_nxt_s;
    logic             skid_ill_r, skid_ill_nxt_s;
    logic             in_ready_r;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             accept_s;
    logic             out_free_s;

    assign opcode_s   = in_inst[6:0];
    assign funct3_s   = in_inst[14:12];
    assign is_shift_s = (funct3_s == 3'b001) || (funct3_s == 3'b101);
    assign imm_s_s    = {in_inst[31:25], in_inst[11:7]};
    assign imm_b_s    = {in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u_s    = {in_inst[31:12], 12'h000};
    assign imm_j_s    = {in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    // Opcode decode and immediate assembly for the incoming instruction.
    always_comb begin
        dec_imm_s = '0;
        dec_fmt_s = FMT_ILL;
        dec_ill_s = 1'b1;
        case (opcode_s)
            OP_LOAD, OP_JALR: begin
                dec_imm_s = XLEN'($signed(in_inst[31:20]));
                dec_fmt_s = FMT_I;
                dec_ill_s = 1'b0;
            end
            OP_IMM: begin
                dec_fmt_s = FMT_I;
                dec_ill_s = 1'b0;
                // Shift amounts are zero-extended; RV64 uses a 6-bit shamt.
                if (is_shift_s) begin
                    if (XLEN == 64) begin
                        dec_imm_s = XLEN'(in_inst[25:20]);
                    end else begin
                        dec_imm_s = XLEN'(in_inst[24:20]);
                    end
                end else begin
                    dec_imm_s = XLEN'($signed(in_inst[31:20]));
                end
            end
            OP_IMM32: begin
                if (XLEN == 64) begin
                    dec_fmt_s = FMT_I;
                    dec_ill_s = 1'b0;
                    if (is_shift_s) begin
                        dec_imm_s = XLEN'(in_inst[24:20]);
                    end else begin
                        dec_imm_s = XLEN'($signed(in_inst[31:20]));
                    end
                end else begin
                    dec_fmt_s = FMT_ILL;
                    dec_ill_s = 1'b1;
                end
            end
            OP_STORE: begin
                dec_imm_s = XLEN'($signed(imm_s_s));
                dec_fmt_s = FMT_S;
                dec_ill_s = 1'b0;
            end
            OP_BRANCH: begin
                dec_imm_s = XLEN'($signed(imm_b_s));
                dec_fmt_s = FMT_B;
                dec_ill_s = 1'b0;
            end
            OP_LUI, OP_AUIPC: begin
                dec_imm_s = XLEN'($signed(imm_u_s));
                dec_fmt_s = FMT_U;
                dec_ill_s = 1'b0;
            end
            OP_JAL: begin
                dec_imm_s = XLEN'($signed(imm_j_s));
                dec_fmt_s = FMT_J;
                dec_ill_s = 1'b0;
            end
            OP_REG: begin
                dec_fmt_s = FMT_R;
                dec_ill_s = 1'b0;
            end
            OP_REG32: begin
                if (XLEN == 64) begin
                    dec_fmt_s = FMT_R;
                    dec_ill_s = 1'b0;
                end else begin
                    dec_fmt_s = FMT_ILL;
                    dec_ill_s = 1'b1;
                end
            end
            default: begin
                dec_imm_s = '0;
                dec_fmt_s = FMT_ILL;
                dec_ill_s = 1'b1;
            end
        endcase
    end

    assign accept_s   = in_valid && in_ready_r;
    assign out_free_s = !out_valid_r || out_ready;

    // Next-state for the output/skid pair; in_ready is only high when the skid is empty.
    always_comb begin
        out_valid_nxt_s  = out_valid_r;
        out_imm_nxt_s    = out_imm_r;
        out_fmt_nxt_s    = out_fmt_r;
        out_ill_nxt_s    = out_ill_r;
        skid_valid_nxt_s = skid_valid_r;
        skid_imm_nxt_s   = skid_imm_r;
        skid_fmt_nxt_s   = skid_fmt_r;
        skid_ill_nxt_s   = skid_ill_r;
        if (out_free_s) begin
            if (skid_valid_r) begin
                out_valid_nxt_s  = 1'b1;
                out_imm_nxt_s    = skid_imm_r;
                out_fmt_nxt_s    = skid_fmt_r;
                out_ill_nxt_s    = skid_ill_r;
                skid_valid_nxt_s = 1'b0;
            end else if (accept_s) begin
                out_valid_nxt_s = 1'b1;
                out_imm_nxt_s   = dec_imm_s;
                out_fmt_nxt_s   = dec_fmt_s;
                out_ill_nxt_s   = dec_ill_s;
            end else begin
                out_valid_nxt_s = 1'b0;
            end
        end else begin
            if (accept_s) begin
                skid_valid_nxt_s = 1'b1;
                skid_imm_nxt_s   = dec_imm_s;
                skid_fmt_nxt_s   = dec_fmt_s;
                skid_ill_nxt_s   = dec_ill_s;
            end else begin
                skid_valid_nxt_s = skid_valid_r;
            end
        end
    end

    // Saturating illegal counter; clear wins over increment.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clr_cnt) begin
            cnt_nxt_s = '0;
        end else if (out_valid_r && out_ready && out_ill_r && (cnt_r != '1)) begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            out_imm_r    <= '0;
            out_fmt_r    <= FMT_R;
            out_ill_r    <= 1'b0;
            skid_valid_r <= 1'b0;
            skid_imm_r   <= '0;
            skid_fmt_r   <= FMT_R;
            skid_ill_r   <= 1'b0;
            in_ready_r   <= 1'b1;
            cnt_r        <= '0;
        end else begin
            out_valid_r  <= out_valid_nxt_s;
            out_imm_r    <= out_imm_nxt_s;
            out_fmt_r    <= out_fmt_nxt_s;
            out_ill_r    <= out_ill_nxt_s;
            skid_valid_r <= skid_valid_nxt_s;
            skid_imm_r   <= skid_imm_nxt_s;
            skid_fmt_r   <= skid_fmt_nxt_s;
            skid_ill_r   <= skid_ill_nxt_s;
            in_ready_r   <= !skid_valid_nxt_s;
            cnt_r        <= cnt_nxt_s;
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_imm     = out_imm_r;
    assign out_fmt     = out_fmt_r;
    assign out_illegal = out_ill_r;
    assign illegal_cnt = cnt_r;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: an XLEN=32/CNT_W=2 instance and an XLEN=64 instance
// driven from a vector table, plus backpressure, counter and reset sequences.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        v32, r32, ov32, rdy32, ill32, clr32;
    logic [31:0] inst32, imm32;
    logic [2:0]  fmt32;
    logic [1:0]  cnt32;

    logic        v64, r64, ov64, rdy64, ill64, clr64;
    logic [31:0] inst64;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic [15:0] cnt64;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        is64;
        logic [31:0] inst;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    vec_t tbl [0:15];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .CNT_W(2)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(r32), .in_inst(inst32),
        .out_valid(ov32), .out_ready(rdy32), .out_imm(imm32), .out_fmt(fmt32),
        .out_illegal(ill32), .illegal_cnt(cnt32), .clr_cnt(clr32)
    );

    imm_gen_pipe #(.XLEN(64), .CNT_W(16)) u64 (
        .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(r64), .in_inst(inst64),
        .out_valid(ov64), .out_ready(rdy64), .out_imm(imm64), .out_fmt(fmt64),
        .out_illegal(ill64), .illegal_cnt(cnt64), .clr_cnt(clr64)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] bp_inst [0:3];
    int idx;
    logic rdy_seen;

    initial begin
        tbl[0]  = '{1'b0, 32'h66208C23, 64'h0000_0000_0000_0678, 3'd2, 1'b0};
        tbl[1]  = '{1'b0, 32'hA1204883, 64'h0000_0000_FFFF_FA12, 3'd1, 1'b0};
        tbl[2]  = '{1'b0, 32'hFE000EE3, 64'h0000_0000_FFFF_FFFC, 3'd3, 1'b0};
        tbl[3]  = '{1'b0, 32'h123450B7, 64'h0000_0000_1234_5000, 3'd4, 1'b0};
        tbl[4]  = '{1'b0, 32'h0080006F, 64'h0000_0000_0000_0008, 3'd5, 1'b0};
        tbl[5]  = '{1'b0, 32'h01F09093, 64'h0000_0000_0000_001F, 3'd1, 1'b0};
        tbl[6]  = '{1'b0, 32'h4030D093, 64'h0000_0000_0000_0003, 3'd1, 1'b0};
        tbl[7]  = '{1'b0, 32'h002081B3, 64'h0000_0000_0000_0000, 3'd0, 1'b0};
        tbl[8]  = '{1'b0, 32'h0000001B, 64'h0000_0000_0000_0000, 3'd7, 1'b1};
        tbl[9]  = '{1'b0, 32'h0000003B, 64'h0000_0000_0000_0000, 3'd7, 1'b1};
        tbl[10] = '{1'b1, 32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0};
        tbl[11] = '{1'b1, 32'h03F09093, 64'h0000_0000_0000_003F, 3'd1, 1'b0};
        tbl[12] = '{1'b1, 32'h0000001B, 64'h0000_0000_0000_0000, 3'd1, 1'b0};
        tbl[13] = '{1'b1, 32'hA1204883, 64'hFFFF_FFFF_FFFF_FA12, 3'd1, 1'b0};
        tbl[14] = '{1'b1, 32'h0000003B, 64'h0000_0000_0000_0000, 3'd0, 1'b0};
        tbl[15] = '{1'b1, 32'h123450B7, 64'h0000_0000_1234_5000, 3'd4, 1'b0};
        bp_inst[0] = 32'h00100013;
        bp_inst[1] = 32'h00200013;
        bp_inst[2] = 32'h00300013;
        bp_inst[3] = 32'h00400013;

        v32 = 1'b0; inst32 = 32'h0; rdy32 = 1'b1; clr32 = 1'b0;
        v64 = 1'b0; inst64 = 32'h0; rdy64 = 1'b1; clr64 = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) tick();
        chk("rst_out_valid", {63'd0, ov32}, 64'd0);
        chk("rst_in_ready", {63'd0, r32}, 64'd1);
        chk("rst_out_imm", {32'd0, imm32}, 64'd0);
        chk("rst_out_fmt", {61'd0, fmt32}, 64'd0);
        chk("rst_out_illegal", {63'd0, ill32}, 64'd0);
        chk("rst_cnt", {62'd0, cnt32}, 64'd0);
        chk("rst64_in_ready", {63'd0, r64}, 64'd1);
        rst_n = 1'b1;
        tick();

        // Table: one instruction per cycle, result checked one edge after acceptance.
        for (int i = 0; i < 16; i++) begin
            v32 = !tbl[i].is64; inst32 = tbl[i].inst;
            v64 = tbl[i].is64;  inst64 = tbl[i].inst;
            tick();
            if (tbl[i].is64) begin
                chk($sformatf("v%0d_valid64", i), {63'd0, ov64}, 64'd1);
                chk($sformatf("v%0d_imm64", i), imm64, tbl[i].imm);
                chk($sformatf("v%0d_fmt64", i), {61'd0, fmt64}, {61'd0, tbl[i].fmt});
                chk($sformatf("v%0d_ill64", i), {63'd0, ill64}, {63'd0, tbl[i].ill});
            end else begin
                chk($sformatf("v%0d_valid32", i), {63'd0, ov32}, 64'd1);
                chk($sformatf("v%0d_imm32", i), {32'd0, imm32}, tbl[i].imm);
                chk($sformatf("v%0d_fmt32", i), {61'd0, fmt32}, {61'd0, tbl[i].fmt});
                chk($sformatf("v%0d_ill32", i), {63'd0, ill32}, {63'd0, tbl[i].ill});
            end
        end
        v32 = 1'b0; v64 = 1'b0;
        tick();
        chk("drain_valid32", {63'd0, ov32}, 64'd0);

        // Backpressure: out_ready low, offer 4 instructions for 6 cycles.
        rdy32 = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            v32 = 1'b1; inst32 = bp_inst[idx];
            rdy_seen = r32;
            tick();
            if (rdy_seen) idx++;
            chk($sformatf("bp_hold_imm_c%0d", c), {32'd0, imm32}, 64'd1);
            if (c >= 1) chk($sformatf("bp_in_ready_c%0d", c), {63'd0, r32}, 64'd0);
        end
        chk("bp_accepted", idx, 64'd2);

        // Release: all four delivered on consecutive cycles in order.
        rdy32 = 1'b1;
        for (int c = 0; c < 4; c++) begin
            v32 = (idx < 4); inst32 = bp_inst[idx < 4 ? idx : 3];
            rdy_seen = r32;
            chk($sformatf("rel_valid_c%0d", c), {63'd0, ov32}, 64'd1);
            chk($sformatf("rel_imm_c%0d", c), {32'd0, imm32}, 64'(c + 1));
            tick();
            if (rdy_seen && v32) idx++;
        end
        v32 = 1'b0;
        chk("rel_all_accepted", idx, 64'd4);
        chk("rel_empty", {63'd0, ov32}, 64'd0);

        // Counter: clear, then 5 illegal instructions saturate at 3; clear on the 6th.
        clr32 = 1'b1;
        tick();
        clr32 = 1'b0;
        chk("cnt_cleared", {62'd0, cnt32}, 64'd0);
        for (int k = 0; k < 6; k++) begin
            v32 = 1'b1; inst32 = 32'h0000007F; clr32 = (k == 5);
            tick();
            chk($sformatf("ill_flag_k%0d", k), {63'd0, ill32}, 64'd1);
            chk($sformatf("ill_fmt_k%0d", k), {61'd0, fmt32}, 64'd7);
            chk($sformatf("ill_cnt_k%0d", k), {62'd0, cnt32},
                (k == 5) ? 64'd0 : ((k > 3) ? 64'd3 : 64'(k)));
        end
        v32 = 1'b0; clr32 = 1'b0;
        tick();
        chk("cnt_after_clr", {62'd0, cnt32}, 64'd1);

        // Reset mid-stream with both registers full.
        rdy32 = 1'b0;
        v32 = 1'b1; inst32 = 32'h0000007F;
        repeat (2) tick();
        v32 = 1'b0;
        chk("full_in_ready", {63'd0, r32}, 64'd0);
        chk("full_valid", {63'd0, ov32}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_valid", {63'd0, ov32}, 64'd0);
        chk("mrst_in_ready", {63'd0, r32}, 64'd1);
        chk("mrst_cnt", {62'd0, cnt32}, 64'd0);
        chk("mrst_illegal", {63'd0, ill32}, 64'd0);
        tick();
        rst_n = 1'b1;
        rdy32 = 1'b1;
        tick();
        chk("post_rst_valid", {63'd0, ov32}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
